// File: rtl/sweep_monitor_if.sv
// Bundles the observed counter value, error-clear and all monitor results.
// The bench drives through master; the monitor consumes through slave.
interface sweep_monitor_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] count;
    logic             clr_err;
    logic             dir_valid;
    logic             dir;
    logic             peak;
    logic             trough;
    logic [15:0]      sweeps;
    logic [15:0]      period;
    logic             in_window;
    logic             step_err;
    logic             stall_err;

    modport master (
        output count, clr_err,
        input  dir_valid, dir, peak, trough, sweeps, period,
               in_window, step_err, stall_err
    );

    modport slave (
        input  count, clr_err,
        output dir_valid, dir, peak, trough, sweeps, period,
               in_window, step_err, stall_err
    );
endinterface

// File: rtl/sweep_monitor.sv
// Passive observer of an auto-reversing up/down counter: direction, turnarounds,
// sweep period/count, hysteresis window and sticky step/stall errors; 1-cycle latency.
module sweep_monitor #(
    parameter int WIDTH     = 8,
    parameter int LO_TH     = 64,
    parameter int HI_TH     = 192,
    parameter int STALL_MAX = 4
) (
    input  logic           clk,
    input  logic           rst,
    sweep_monitor_if.slave bus
);
    typedef enum logic [1:0] {S_INIT, S_SYNC, S_UP, S_DOWN} state_t;

    localparam int               SW        = $clog2(STALL_MAX + 2);
    localparam logic [WIDTH-1:0] W_ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] W_LO      = WIDTH'(LO_TH);
    localparam logic [WIDTH-1:0] W_HI      = WIDTH'(HI_TH);
    localparam logic [SW-1:0]    STALL_LIM = SW'(STALL_MAX);
    localparam logic [SW-1:0]    S_ONE     = SW'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_prev;
    logic [SW-1:0]    r_stall_cnt;
    logic [15:0]      r_per_cnt;
    logic             r_have_trough;
    logic             r_peak;
    logic             r_trough;
    logic [15:0]      r_sweeps;
    logic [15:0]      r_period;
    logic             r_in_window;
    logic             r_step_err;
    logic             r_stall_err;

    logic w_inc, w_dec, w_same, w_jump;
    logic w_peak_nxt, w_trough_nxt, w_jump_evt, w_active, w_stall_evt;

    // Non-modular steps: the guards turn 255->0 and 0->255 into jumps.
    assign w_inc  = (r_prev != '1) && (bus.count == r_prev + W_ONE);
    assign w_dec  = (r_prev != '0) && (bus.count == r_prev - W_ONE);
    assign w_same = (bus.count == r_prev);
    assign w_jump = !(w_inc || w_dec || w_same);

    assign w_active    = (r_state == S_UP) || (r_state == S_DOWN);
    assign w_stall_evt = w_same && (r_state != S_INIT) && (r_stall_cnt >= STALL_LIM);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_INIT;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_peak_nxt   = 1'b0;
        w_trough_nxt = 1'b0;
        w_jump_evt   = 1'b0;
        case (r_state)
            S_INIT: w_state_nxt = S_SYNC;
            S_SYNC: begin
                if (w_inc)       w_state_nxt = S_UP;
                else if (w_dec)  w_state_nxt = S_DOWN;
                else if (w_jump) w_jump_evt  = 1'b1;
            end
            S_UP: begin
                if (w_dec) begin
                    w_state_nxt = S_DOWN;
                    w_peak_nxt  = 1'b1;
                end else if (w_jump) begin
                    w_state_nxt = S_SYNC;
                    w_jump_evt  = 1'b1;
                end
            end
            S_DOWN: begin
                if (w_inc) begin
                    w_state_nxt  = S_UP;
                    w_trough_nxt = 1'b1;
                end else if (w_jump) begin
                    w_state_nxt = S_SYNC;
                    w_jump_evt  = 1'b1;
                end
            end
            default: w_state_nxt = S_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prev        <= '0;
            r_stall_cnt   <= '0;
            r_per_cnt     <= '0;
            r_have_trough <= 1'b0;
            r_peak        <= 1'b0;
            r_trough      <= 1'b0;
            r_sweeps      <= '0;
            r_period      <= '0;
            r_in_window   <= 1'b0;
            r_step_err    <= 1'b0;
            r_stall_err   <= 1'b0;
        end else begin
            r_prev   <= bus.count;
            r_peak   <= w_peak_nxt;
            r_trough <= w_trough_nxt;

            if (r_state == S_INIT || !w_same) r_stall_cnt <= '0;
            else if (r_stall_cnt <= STALL_LIM) r_stall_cnt <= r_stall_cnt + S_ONE;

            if (w_jump_evt || w_trough_nxt)      r_per_cnt <= '0;
            else if (w_active && r_per_cnt != '1) r_per_cnt <= r_per_cnt + 16'd1;

            // The first trough after sync only opens the measurement window.
            if (w_trough_nxt) begin
                r_have_trough <= 1'b1;
                if (r_have_trough) begin
                    r_period <= (r_per_cnt == '1) ? 16'hFFFF : r_per_cnt + 16'd1;
                    if (r_sweeps != '1) r_sweeps <= r_sweeps + 16'd1;
                end
            end else if (w_jump_evt) begin
                r_have_trough <= 1'b0;
            end

            if (bus.count >= W_HI)      r_in_window <= 1'b1;
            else if (bus.count <= W_LO) r_in_window <= 1'b0;

            r_step_err  <= w_jump_evt  || (r_step_err  && !bus.clr_err);
            r_stall_err <= w_stall_evt || (r_stall_err && !bus.clr_err);
        end
    end

    assign bus.dir_valid = w_active;
    assign bus.dir       = (r_state == S_UP);
    assign bus.peak      = r_peak;
    assign bus.trough    = r_trough;
    assign bus.sweeps    = r_sweeps;
    assign bus.period    = r_period;
    assign bus.in_window = r_in_window;
    assign bus.step_err  = r_step_err;
    assign bus.stall_err = r_stall_err;
endmodule

// File: tb/tb_sweep_monitor.sv
// Directed bench for sweep_monitor: behavioural model compared every cycle,
// plus hand-computed checkpoints for triangle, hysteresis, jump, wrap, stall and reset.
module tb_sweep_monitor;
    localparam int WIDTH     = 8;
    localparam int LO_TH     = 64;
    localparam int HI_TH     = 192;
    localparam int STALL_MAX = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    sweep_monitor_if #(.WIDTH(WIDTH)) bus ();

    sweep_monitor #(
        .WIDTH(WIDTH), .LO_TH(LO_TH), .HI_TH(HI_TH), .STALL_MAX(STALL_MAX)
    ) dut (
        .clk(clk),
        .rst(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: direction as +1/-1/0 (unknown), periods from edge timestamps.
    int m_prev = 0, m_dir = 0, m_run = 0, m_cyc = 0, m_last = 0;
    int m_sweeps = 0, m_period = 0;
    bit m_started = 0, m_have = 0, m_peak = 0, m_trough = 0;
    bit m_win = 0, m_step_err = 0, m_stall_err = 0;
    int d;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_prev = 0; m_dir = 0; m_run = 0; m_cyc = 0; m_last = 0;
            m_sweeps = 0; m_period = 0;
            m_started = 0; m_have = 0; m_peak = 0; m_trough = 0;
            m_win = 0; m_step_err = 0; m_stall_err = 0;
        end else begin
            d = int'(bus.count) - m_prev;
            m_peak = 0;
            m_trough = 0;
            if (bus.clr_err) begin
                m_step_err  = 0;
                m_stall_err = 0;
            end
            if (m_started) begin
                if (d == 0) begin
                    m_run++;
                    if (m_run > STALL_MAX) m_stall_err = 1;
                end else begin
                    m_run = 0;
                end
                if (d == 1) begin
                    if (m_dir == -1) m_trough = 1;
                    m_dir = 1;
                end else if (d == -1) begin
                    if (m_dir == 1) m_peak = 1;
                    m_dir = -1;
                end else if (d != 0) begin
                    m_step_err = 1;
                    m_dir = 0;
                    m_have = 0;
                end
                if (m_trough) begin
                    if (m_have) begin
                        m_sweeps = (m_sweeps < 65535) ? m_sweeps + 1 : 65535;
                        m_period = (m_cyc - m_last < 65535) ? m_cyc - m_last : 65535;
                    end
                    m_have = 1;
                    m_last = m_cyc;
                end
            end
            m_started = 1;
            if (int'(bus.count) >= HI_TH)      m_win = 1;
            else if (int'(bus.count) <= LO_TH) m_win = 0;
            m_prev = int'(bus.count);
            m_cyc++;
        end
    end

    logic [38:0] cmp_act, cmp_exp;

    always @(negedge clk) begin
        cmp_act = {bus.dir_valid, bus.dir, bus.peak, bus.trough, bus.sweeps, bus.period,
                   bus.in_window, bus.step_err, bus.stall_err};
        cmp_exp = {m_dir != 0, m_dir == 1, m_peak, m_trough, 16'(m_sweeps), 16'(m_period),
                   m_win, m_step_err, m_stall_err};
        n_tests++;
        if (cmp_act !== cmp_exp) begin
            n_fail++;
            $display("FAIL model_cmp t=%0t got %h expected %h", $time, cmp_act, cmp_exp);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input int v, input bit clr = 1'b0);
        bus.count   = WIDTH'(v);
        bus.clr_err = clr;
        @(negedge clk);
        bus.clr_err = 1'b0;
    endtask

    initial begin
        bus.count   = '0;
        bus.clr_err = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_dir_valid", int'(bus.dir_valid), 0);
        chk("rst_sweeps", int'(bus.sweeps), 0);
        chk("rst_step_err", int'(bus.step_err), 0);
        rst_n = 1'b1;

        for (int rep = 0; rep < 4; rep++) begin
            drive(0);
            drive(1);
            if (rep == 0) begin
                chk("dir_valid_2nd_edge", int'(bus.dir_valid), 1);
                chk("dir_up_start", int'(bus.dir), 1);
            end else begin
                chk("trough_pulse", int'(bus.trough), 1);
                chk("sweeps_tri", int'(bus.sweeps), rep - 1);
                chk("period_tri", int'(bus.period), (rep >= 2) ? 510 : 0);
            end
            if (rep == 3) break;
            for (int v = 2; v <= 255; v++) drive(v);
            drive(254);
            chk("peak_pulse", int'(bus.peak), 1);
            chk("dir_down", int'(bus.dir), 0);
            drive(253);
            chk("peak_one_cycle", int'(bus.peak), 0);
            for (int v = 252; v >= 1; v--) drive(v);
        end

        for (int v = 2; v <= 191; v++) drive(v);
        chk("win_below_hi", int'(bus.in_window), 0);
        drive(192);
        chk("win_set_192", int'(bus.in_window), 1);
        for (int v = 193; v <= 200; v++) drive(v);
        for (int v = 199; v >= 100; v--) drive(v);
        chk("win_hold_100", int'(bus.in_window), 1);
        for (int v = 99; v >= 65; v--) drive(v);
        chk("win_hold_65", int'(bus.in_window), 1);
        drive(64);
        chk("win_clear_64", int'(bus.in_window), 0);
        for (int v = 63; v >= 9; v--) drive(v);
        drive(10);
        chk("trough_at_10", int'(bus.trough), 1);
        chk("sweeps_3", int'(bus.sweeps), 3);
        chk("period_391", int'(bus.period), 391);

        drive(40);
        chk("jump_step_err", int'(bus.step_err), 1);
        chk("jump_dir_valid", int'(bus.dir_valid), 0);
        chk("jump_sweeps_hold", int'(bus.sweeps), 3);
        chk("jump_period_hold", int'(bus.period), 391);
        drive(41);
        drive(40);
        drive(39);
        drive(40);
        chk("trough_after_sync", int'(bus.trough), 1);
        chk("sweeps_no_inc", int'(bus.sweeps), 3);
        chk("period_no_upd", int'(bus.period), 391);

        drive(41, 1'b1);
        chk("clr_step_err", int'(bus.step_err), 0);
        for (int v = 42; v <= 255; v++) drive(v);
        drive(0);
        chk("wrap_step_err", int'(bus.step_err), 1);
        chk("wrap_no_peak", int'(bus.peak), 0);
        chk("wrap_dir_valid", int'(bus.dir_valid), 0);

        for (int v = 1; v <= 76; v++) drive(v);
        repeat (5) drive(77);
        chk("stall5_no_err", int'(bus.stall_err), 0);
        repeat (6) drive(78);
        chk("stall6_err", int'(bus.stall_err), 1);
        chk("stall_still_valid", int'(bus.dir_valid), 1);
        chk("stall_still_up", int'(bus.dir), 1);
        drive(79, 1'b1);
        chk("clr_stall_err", int'(bus.stall_err), 0);
        chk("clr_step_err2", int'(bus.step_err), 0);
        drive(100, 1'b1);
        chk("err_beats_clr", int'(bus.step_err), 1);

        drive(101);
        drive(102);
        #2 rst_n = 1'b0;
        #1;
        chk("async_step_err", int'(bus.step_err), 0);
        chk("async_sweeps", int'(bus.sweeps), 0);
        chk("async_period", int'(bus.period), 0);
        chk("async_dir_valid", int'(bus.dir_valid), 0);
        bus.count = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0);
        chk("rel_dir_valid_1st", int'(bus.dir_valid), 0);
        drive(1);
        chk("rel_dir_valid_2nd", int'(bus.dir_valid), 1);
        chk("rel_dir_up", int'(bus.dir), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
